keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, gives the clk cycles per scan tick (1 ms at 100 MHz); legal range is 2 or more.
REQ-002 Parameter DEBOUNCE_TICKS, default 20, gives the consecutive stable scan ticks needed for press or release; legal range is 1 to 255.
REQ-003 clk  input  1  system clock, 100 MHz; every register uses its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserting it immediately forces every register to its reset value.
REQ-005 row  input  4  raw keypad rows, active-low (a pressed key pulls its row low), asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, one-cold, registered.
REQ-007 key_code  output  4  code of the last registered key, equal to row_idx*4 + col_idx, registered.
REQ-008 key_valid  output  1  high when an unread key is held in key_code.
REQ-009 key_ack  input  1  single-cycle pulse from the CPU read decode; consumes the key.
REQ-010 overrun  output  1  sticky; a key was registered while key_valid was still high.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer (reset value 4'hF); all logic uses only the synchronized value (row_s).
REQ-012 A divider SHALL count 0..SCAN_DIV-1 and wrap; tick is a single-cycle pulse on the count SCAN_DIV-1; the divider free-runs in every state.
REQ-013 The FSM SHALL have exactly three states, SCAN, DEBOUNCE and HELD, with SCAN as the reset state.
REQ-014 SCAN: on tick with row_s==4'hF, col SHALL rotate 1110->1101->1011->0111->1110.
REQ-015 SCAN: on tick with any row_s bit low, col SHALL hold, the lowest-index low row SHALL be captured as row_idx, the debounce count SHALL clear, and the FSM SHALL enter DEBOUNCE.
REQ-016 DEBOUNCE: on tick with row_s[row_idx] low, the count SHALL increment; on reaching DEBOUNCE_TICKS the key SHALL register (REQ-019) and the FSM SHALL enter HELD with the count cleared.
REQ-017 DEBOUNCE: on tick with row_s[row_idx] high, no key SHALL register, col SHALL advance one position, and the FSM SHALL return to SCAN.
REQ-018 HELD: col SHALL hold; each tick with row_s[row_idx] high SHALL increment the release count, and each tick with it low SHALL clear that count; on reaching DEBOUNCE_TICKS col SHALL advance and the FSM SHALL return to SCAN.
REQ-019 Key register: key_code <= {row_idx, col_idx} and key_valid <= 1, both in the same clk as the qualifying tick.
REQ-020 Key register while key_valid=1 and key_ack=0: overrun <= 1; key_code keeps the old value (first key is preserved).
REQ-021 key_ack=1 with no register event: key_valid <= 0 and overrun <= 0 on the next edge.
REQ-022 key_ack coinciding with a key register: the new key SHALL load, key_valid SHALL stay 1, and overrun SHALL be cleared.
REQ-023 key_ack while key_valid=0 SHALL have no effect.
REQ-024 Only one key is tracked at a time; other rows and columns are ignored outside SCAN.
REQ-025 Press-to-valid latency: from row_s stable low at the tick that locks the column, key_valid SHALL rise exactly DEBOUNCE_TICKS ticks later.

Reset
REQ-026 During reset: col=4'b1110, key_code=0, key_valid=0, overrun=0, FSM=SCAN, divider=0, both counts=0, synchronizer=4'hF.
REQ-027 Reset asserted mid-DEBOUNCE or mid-HELD SHALL discard the in-progress key; after release scanning SHALL restart from col=1110.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-028 Reset, then idle rows=4'hF for 20 cycles -> col sequence 1110,1101,1011,0111,1110 changing every 4 clk; key_valid=0 throughout.
REQ-029 Hold row[1] low whenever col[2] is low -> column locks at 1011; key_valid=1 with key_code=6 on the 3rd tick after the lock; col holds until 3 ticks after release.
REQ-030 row[0] low for 1 tick only, then high -> no key_valid, col advances and scanning resumes.
REQ-031 Press key 6, then a single-cycle key_ack -> key_valid=0 next cycle, key_code stays 6.
REQ-032 Press key 6 and release it, then press key 1 with no ack -> overrun=1, key_code=6; then key_ack -> key_valid=0 and overrun=0.
REQ-033 reset pulsed low while in HELD -> col=1110 and all outputs at reset values; no key from the aborted press.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce and a one-deep key register.
// Latency: key_valid rises DEBOUNCE_TICKS scan ticks after the tick that locks a column.
// Backpressure: none; an unread key blocks new codes (first key kept) and raises sticky overrun.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       row_m;
  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [1:0]       low_idx;
  logic [7:0]       deb_cnt;
  logic [7:0]       rel_cnt;
  logic             row_hit;
  logic             deb_last;
  logic             rel_last;
  logic             key_load;
  logic [3:0]       col_next;

  // Two-flop synchronizer for the asynchronous row lines; idle (no key) is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Free-running scan divider; tick marks the last count of each period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Decode of the current column, the lowest pressed row and the debounce terminal counts.
  always_comb begin
    tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
    col_next = {col[2:0], col[3]};
    case (col)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    if (!row_s[0])      low_idx = 2'd0;
    else if (!row_s[1]) low_idx = 2'd1;
    else if (!row_s[2]) low_idx = 2'd2;
    else                low_idx = 2'd3;
    row_hit  = ~row_s[row_idx];
    deb_last = ((deb_cnt + 8'd1) == 8'(DEBOUNCE_TICKS));
    rel_last = ((rel_cnt + 8'd1) == 8'(DEBOUNCE_TICKS));
    key_load = tick && (state == DEBOUNCE) && row_hit && deb_last;
  end

  // Scan/debounce FSM plus the registered key, valid and overrun outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 4'b1110;
      row_idx   <= 2'd0;
      deb_cnt   <= 8'd0;
      rel_cnt   <= 8'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_s == 4'hF) begin
              col <= col_next;
            end else begin
              row_idx <= low_idx;
              deb_cnt <= 8'd0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_hit) begin
              if (deb_last) begin
                deb_cnt <= 8'd0;
                rel_cnt <= 8'd0;
                state   <= HELD;
              end else begin
                deb_cnt <= deb_cnt + 8'd1;
              end
            end else begin
              // Bounce or glitch: drop the candidate and move on to the next column.
              col   <= col_next;
              state <= SCAN;
            end
          end
          HELD: begin
            if (!row_hit) begin
              if (rel_last) begin
                rel_cnt <= 8'd0;
                col     <= col_next;
                state   <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + 8'd1;
              end
            end else begin
              rel_cnt <= 8'd0;
            end
          end
          default: state <= SCAN;
        endcase
      end

      // A new key wins over an ack in the same cycle; an unread key is never overwritten.
      if (key_load) begin
        if (key_valid && !key_ack) begin
          overrun <= 1'b1;
        end else begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
          overrun   <= 1'b0;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// A keypad model pulls a row low while the pressed key's column is driven.
// Table vectors, hand-timed corner sequences and a randomized transaction-level model.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;

  int checks;
  int errors;
  int edge_no;

  // Keypad model: one pressed key at (kp_r, kp_c), plus a direct row override mask.
  logic       kp_on;
  logic [1:0] kp_r;
  logic [1:0] kp_c;
  logic [3:0] glitch;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    if (kp_on && (col[kp_c] == 1'b0)) row[kp_r] = 1'b0;
    row = row & glitch;
  end

  // Clock edges counted since the last reset release.
  always @(posedge clk) begin
    if (!reset) edge_no = 0;
    else        edge_no = edge_no + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_edge(input int n);
    while (edge_no < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    key_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Long press (15 ticks) then release long enough for the release debounce.
  task automatic press_release(input logic [1:0] r, input logic [1:0] c);
    kp_r  = r;
    kp_c  = c;
    kp_on = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    kp_on = 1'b0;
    repeat (32) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] row_in;
    int         at_edge;
    logic [3:0] exp_col;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[5];

  // Transaction-level reference: one-deep key register with sticky overrun.
  logic       m_valid;
  logic [3:0] m_code;
  logic       m_ovr;

  initial begin
    tbl[0] = '{4'hF,  2, 4'b1110, 1'b0};
    tbl[1] = '{4'hF,  6, 4'b1101, 1'b0};
    tbl[2] = '{4'hF, 10, 4'b1011, 1'b0};
    tbl[3] = '{4'hF, 14, 4'b0111, 1'b0};
    tbl[4] = '{4'hF, 18, 4'b1110, 1'b0};

    checks  = 0;
    errors  = 0;
    edge_no = 0;
    kp_on   = 1'b0;
    kp_r    = 2'd0;
    kp_c    = 2'd0;
    glitch  = 4'hF;
    key_ack = 1'b0;
    reset   = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_col", col, 4'b1110);
    chk("reset_code", key_code, 0);
    chk("reset_valid", key_valid, 0);
    chk("reset_ovr", overrun, 0);

    // Idle scan rotation, one column step every 4 clocks
    do_reset();
    for (int i = 0; i < 5; i++) begin
      glitch = tbl[i].row_in;
      wait_edge(tbl[i].at_edge);
      chk($sformatf("idle_col[%0d]", i), col, tbl[i].exp_col);
      chk($sformatf("idle_valid[%0d]", i), key_valid, tbl[i].exp_valid);
    end

    // Key 6 (row 1, col 2): lock on tick at edge 12, register on edge 24
    do_reset();
    kp_r = 2'd1; kp_c = 2'd2; kp_on = 1'b1;
    wait_edge(13);
    chk("lock_col", col, 4'b1011);
    wait_edge(23);
    chk("deb_valid_low", key_valid, 0);
    chk("deb_col_hold", col, 4'b1011);
    wait_edge(24);
    chk("press_valid", key_valid, 1);
    chk("press_code", key_code, 6);
    wait_edge(30);
    kp_on = 1'b0;
    wait_edge(43);
    chk("held_col", col, 4'b1011);
    wait_edge(44);
    chk("release_col", col, 4'b0111);
    // Single-cycle ack consumes the key
    wait_edge(45);
    key_ack = 1'b1;
    wait_edge(46);
    key_ack = 1'b0;
    chk("ack_valid", key_valid, 0);
    chk("ack_code", key_code, 6);
    chk("ack_ovr", overrun, 0);

    // Overrun: key 6 then key 1 without ack, then ack clears both
    press_release(2'd1, 2'd2);
    chk("ovr_first_valid", key_valid, 1);
    chk("ovr_first_code", key_code, 6);
    press_release(2'd0, 2'd1);
    chk("ovr_set", overrun, 1);
    chk("ovr_code_kept", key_code, 6);
    pulse_ack();
    chk("ovr_ack_valid", key_valid, 0);
    chk("ovr_ack_ovr", overrun, 0);

    // One-tick glitch on row 0 while col 0 is driven: lock, then abandon
    do_reset();
    wait_edge(1);
    glitch = 4'b1110;
    wait_edge(5);
    glitch = 4'hF;
    chk("glitch_lock_col", col, 4'b1110);
    wait_edge(8);
    chk("glitch_adv_col", col, 4'b1101);
    wait_edge(12);
    chk("glitch_resume_col", col, 4'b1011);
    wait_edge(40);
    chk("glitch_no_key", key_valid, 0);

    // Reset while HELD: everything returns to reset values, no stale key
    do_reset();
    kp_r = 2'd1; kp_c = 2'd2; kp_on = 1'b1;
    wait_edge(26);
    reset = 1'b0;
    #1;
    chk("held_rst_col", col, 4'b1110);
    chk("held_rst_valid", key_valid, 0);
    chk("held_rst_code", key_code, 0);
    chk("held_rst_ovr", overrun, 0);
    kp_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_edge(2);
    chk("held_rst_restart_col", col, 4'b1110);
    wait_edge(60);
    chk("held_rst_no_key", key_valid, 0);

    // Reset while DEBOUNCE discards the candidate key
    do_reset();
    kp_r = 2'd1; kp_c = 2'd2; kp_on = 1'b1;
    wait_edge(18);
    reset = 1'b0;
    kp_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_edge(60);
    chk("deb_rst_no_key", key_valid, 0);
    chk("deb_rst_code", key_code, 0);

    // Randomized presses and acks against the transaction-level model
    do_reset();
    m_valid = 1'b0;
    m_code  = 4'd0;
    m_ovr   = 1'b0;
    for (int t = 0; t < 20; t++) begin
      logic [3:0] k;
      k = 4'($urandom_range(0, 15));
      press_release(k[3:2], k[1:0]);
      if (m_valid) begin
        m_ovr = 1'b1;
      end else begin
        m_code  = k;
        m_valid = 1'b1;
        m_ovr   = 1'b0;
      end
      chk($sformatf("rnd_press_valid[%0d]", t), key_valid, m_valid);
      chk($sformatf("rnd_press_code[%0d]", t), key_code, m_code);
      chk($sformatf("rnd_press_ovr[%0d]", t), overrun, m_ovr);
      if ($urandom_range(0, 2) != 0) begin
        pulse_ack();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
        chk($sformatf("rnd_ack_valid[%0d]", t), key_valid, m_valid);
        chk($sformatf("rnd_ack_ovr[%0d]", t), overrun, m_ovr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
